demux32_stream: RTL and testbench

- 1:2 registered demultiplexer: the inverse of the 32-bit 2:1 select mux used in the datapath.
- Accepts one 32-bit word per cycle on a valid/ready input and steers it by select_i to output channel 0 or channel 1.
- Each channel has its own small FIFO, so the two destinations (for example the writeback path and the fault-log path) apply backpressure independently.
- Per-channel delivered-word counters are exposed for fault tracking.

---
 rtl/demux32_stream_pkg.sv | 19 +
 rtl/demux32_stream_fifo.sv | 73 +++++++
 rtl/demux32_stream.sv | 89 ++++++++
 tb/tb_demux32_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux32_stream_pkg.sv
// Shared definitions for the demux32_stream 1:2 registered demultiplexer.
// Channel encodings, default sizing constants and the FIFO pointer-width helper.
package demux32_stream_pkg;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

    // One extra MSB beyond the index lets full and empty be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux32_stream_fifo.sv
// demux_fifo: synchronous FIFO with a registered head word.
// The head register keeps the last popped word while the FIFO is empty.
module demux_fifo
    import demux32_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (do_push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = din;
            wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Reading the next head from mem_d covers a word written this same cycle.
        if (rd_ptr_d != wr_ptr_d) begin
            dout_d = mem_d[rd_ptr_d[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/demux32_stream.sv
// demux32_stream: steers each accepted word to one of two buffered output channels
// and counts the words delivered on each channel.
module demux32_stream
    import demux32_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             select_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data0_o,
    output logic             valid0_o,
    input  logic             ready0_i,
    output logic [WIDTH-1:0] data1_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [CNT_W-1:0] count0_o,
    output logic [CNT_W-1:0] count1_o
);

    logic             full0, full1;
    logic             empty0, empty1;
    logic             push0, push1;
    logic             pop0, pop1;
    logic [CNT_W-1:0] count0_q, count0_d;
    logic [CNT_W-1:0] count1_q, count1_d;

    // Handshakes: a word moves on any edge where valid and ready are both high.
    // ready_o looks only at the selected FIFO's full flag, never at valid_i or
    // at the downstream readys, so a full FIFO refuses even while it drains.
    assign ready_o = (ch_e'(select_i) == CH1) ? ~full1 : ~full0;

    assign push0 = valid_i & ready_o & (ch_e'(select_i) == CH0);
    assign push1 = valid_i & ready_o & (ch_e'(select_i) == CH1);

    assign valid0_o = ~empty0;
    assign valid1_o = ~empty1;
    assign pop0     = valid0_o & ready0_i;
    assign pop1     = valid1_o & ready1_i;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push0),
        .pop   (pop0),
        .din   (data_i),
        .dout  (data0_o),
        .full  (full0),
        .empty (empty0)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push1),
        .pop   (pop1),
        .din   (data_i),
        .dout  (data1_o),
        .full  (full1),
        .empty (empty1)
    );

    // Delivered-word counters wrap freely.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (pop0) count0_d = count0_q + CNT_W'(1);
        if (pop1) count1_d = count1_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign count0_o = count0_q;
    assign count1_o = count1_q;

endmodule

// File: tb/tb_demux32_stream.sv
// Bench for demux32_stream: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a queue-based channel model.
module tb_demux32_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int NVEC  = 10;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             select_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data0_o;
    logic             valid0_o;
    logic             ready0_i;
    logic [WIDTH-1:0] data1_o;
    logic             valid1_o;
    logic             ready1_i;
    logic [CNT_W-1:0] count0_o;
    logic [CNT_W-1:0] count1_o;

    demux32_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i),
        .count0_o (count0_o),
        .count1_o (count1_o)
    );

    // Clock / reset block
    always #5 clk_i = ~clk_i;

    // Scoreboard: one expected queue per channel plus the last delivered word
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [WIDTH-1:0] last0 = '0;
    logic [WIDTH-1:0] last1 = '0;
    int               cnt0 = 0;
    int               cnt1 = 0;
    int               n_cmp = 0;
    int               n_err = 0;

    typedef struct {
        logic        v;
        logic        s;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        rdy;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        int          c0;
        int          c1;
    } vec_t;

    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic v, input logic s, input logic [31:0] d,
                                input logic r0, input logic r1, input logic rdy,
                                input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input int c0, input int c1);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1; t.rdy = rdy;
        t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.c0 = c0; t.c1 = c1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (select_i) return exp_q1.size() < DEPTH;
        return exp_q0.size() < DEPTH;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        valid_i  = v;
        select_i = s;
        data_i   = d;
        ready0_i = r0;
        ready1_i = r1;
    endtask

    // One clock: check ready_o, advance the model at the edge, check outputs after it.
    task automatic cycle();
        logic p0, p1, acc;
        #1;
        chk("ready_o", {31'b0, ready_o}, {31'b0, model_ready()});
        @(posedge clk_i);
        p0  = ready0_i && (exp_q0.size() > 0);
        p1  = ready1_i && (exp_q1.size() > 0);
        acc = valid_i && model_ready();
        if (rst_i) begin
            exp_q0.delete();
            exp_q1.delete();
            last0 = '0;
            last1 = '0;
            cnt0  = 0;
            cnt1  = 0;
        end else begin
            if (p0) begin last0 = exp_q0.pop_front(); cnt0++; end
            if (p1) begin last1 = exp_q1.pop_front(); cnt1++; end
            if (acc) begin
                if (select_i) exp_q1.push_back(data_i);
                else          exp_q0.push_back(data_i);
            end
        end
        #1;
        chk("valid0", {31'b0, valid0_o}, {31'b0, exp_q0.size() != 0});
        chk("data0", data0_o, (exp_q0.size() != 0) ? exp_q0[0] : last0);
        chk("valid1", {31'b0, valid1_o}, {31'b0, exp_q1.size() != 0});
        chk("data1", data1_o, (exp_q1.size() != 0) ? exp_q1[0] : last1);
        chk("count0", 32'(count0_o), 32'(cnt0 % (1 << CNT_W)));
        chk("count1", 32'(count1_o), 32'(cnt1 % (1 << CNT_W)));
    endtask

    initial begin
        int base0, base1;
        logic stalled;

        // Steering, latency, backpressure and full behaviour from a fresh reset
        tbl[0] = mk(1, 0, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0);
        tbl[1] = mk(1, 1, 32'h12345678, 1, 1, 1, 0, 32'hDEADBEEF, 1, 32'h12345678, 1, 0);
        tbl[2] = mk(0, 0, 32'h0, 1, 1, 1, 0, 32'hDEADBEEF, 0, 32'h12345678, 1, 1);
        tbl[3] = mk(1, 0, 32'hA0, 0, 1, 1, 1, 32'hA0, 0, 32'h12345678, 1, 1);
        tbl[4] = mk(1, 0, 32'hA1, 0, 1, 1, 1, 32'hA0, 0, 32'h12345678, 1, 1);
        tbl[5] = mk(1, 0, 32'hA2, 0, 1, 0, 1, 32'hA0, 0, 32'h12345678, 1, 1);
        tbl[6] = mk(0, 1, 32'hA2, 0, 1, 1, 1, 32'hA0, 0, 32'h12345678, 1, 1);
        tbl[7] = mk(1, 0, 32'hA2, 1, 1, 0, 1, 32'hA1, 0, 32'h12345678, 2, 1);
        tbl[8] = mk(1, 0, 32'hA2, 1, 1, 1, 1, 32'hA2, 0, 32'h12345678, 3, 1);
        tbl[9] = mk(0, 0, 32'h0, 1, 1, 1, 0, 32'hA2, 0, 32'h12345678, 4, 1);

        rst_i = 1'b1;
        drive(0, 0, '0, 0, 0);
        cycle();
        cycle();
        rst_i = 1'b0;
        chk("rst_valid0", {31'b0, valid0_o}, 32'd0);
        chk("rst_valid1", {31'b0, valid1_o}, 32'd0);
        chk("rst_count0", 32'(count0_o), 32'd0);
        chk("rst_count1", 32'(count1_o), 32'd0);
        chk("rst_data0", data0_o, 32'd0);
        chk("rst_data1", data1_o, 32'd0);
        select_i = 1'b0;
        #1 chk("rst_ready_sel0", {31'b0, ready_o}, 32'd1);
        select_i = 1'b1;
        #1 chk("rst_ready_sel1", {31'b0, ready_o}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'b0, ready_o}, {31'b0, tbl[i].rdy});
            cycle();
            chk($sformatf("tbl%0d_valid0", i), {31'b0, valid0_o}, {31'b0, tbl[i].v0});
            chk($sformatf("tbl%0d_data0", i), data0_o, tbl[i].d0);
            chk($sformatf("tbl%0d_valid1", i), {31'b0, valid1_o}, {31'b0, tbl[i].v1});
            chk($sformatf("tbl%0d_data1", i), data1_o, tbl[i].d1);
            chk($sformatf("tbl%0d_count0", i), 32'(count0_o), 32'(tbl[i].c0));
            chk($sformatf("tbl%0d_count1", i), 32'(count1_o), 32'(tbl[i].c1));
        end

        // Simultaneous push/pop on ch1 at occupancy 1: no bubbles, order kept
        drive(1, 1, 32'hC000_0000, 1, 0);
        cycle();
        base1 = cnt1;
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 32'hC000_0000 + 32'(i), 1, 1);
            cycle();
            chk("simul_valid1", {31'b0, valid1_o}, 32'd1);
            chk("simul_data1", data1_o, 32'hC000_0000 + 32'(i));
        end
        chk("simul_count1_delta", 32'((count1_o - CNT_W'(base1)) & CNT_W'('1)), 32'd10);
        drive(0, 1, '0, 1, 1);
        cycle();

        // Counter wrap: 17 deliveries on ch0 advance a 4-bit counter by 1
        base0 = cnt0;
        base1 = cnt1;
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 32'hB000_0000 + 32'(i), 1, 1);
            cycle();
        end
        drive(0, 0, '0, 1, 1);
        cycle();
        cycle();
        chk("wrap_count0", 32'(count0_o), 32'((base0 + 1) % 16));
        chk("wrap_count1", 32'(count1_o), 32'(base1 % 16));

        // Reset mid-operation with both FIFOs full
        for (int i = 0; i < 4; i++) begin
            drive(1, i[0], 32'hF000_0000 + 32'(i), 0, 0);
            cycle();
        end
        drive(0, 0, '0, 0, 0);
        #1 chk("full_ready_sel0", {31'b0, ready_o}, 32'd0);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("midrst_valid0", {31'b0, valid0_o}, 32'd0);
        chk("midrst_valid1", {31'b0, valid1_o}, 32'd0);
        chk("midrst_count0", 32'(count0_o), 32'd0);
        chk("midrst_count1", 32'(count1_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1, 1);
            cycle();
            chk("midrst_no_flush0", {31'b0, valid0_o}, 32'd0);
            chk("midrst_no_flush1", {31'b0, valid1_o}, 32'd0);
        end

        // Randomized traffic; the producer holds its word while stalled
        drive(0, 0, '0, 1, 1);
        stalled = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!stalled) begin
                valid_i  = ($urandom_range(0, 3) != 0);
                select_i = 1'($urandom_range(0, 1));
                data_i   = $urandom;
            end
            ready0_i = ($urandom_range(0, 2) != 0);
            ready1_i = ($urandom_range(0, 2) != 0);
            #1;
            stalled = valid_i && !model_ready();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
